// File: rtl/gray_add_sequencer.sv
// Shared gray-code adder: round-robin arbitration between two requesters,
// then a CONV -> ADD -> ENC sequence producing a (W+1)-bit gray sum.
module gray_add_sequencer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         req0,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   output logic         gnt0,
   input  logic         req1,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic         gnt1,
   output logic         busy,
   output logic         out_valid,
   output logic [W:0]   out_gray,
   output logic         out_id,
   output logic [7:0]   ops_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      ADD  = 2'd2,
      ENC  = 2'd3
   } state_t;

   state_t         state_r;
   state_t         next_s;
   logic           take_s;
   logic           sel_id_s;
   logic           cur_id_r;
   logic           last_id_r;
   logic [W-1:0]   op_a_r;
   logic [W-1:0]   op_b_r;
   logic [W-1:0]   bin_a_r;
   logic [W-1:0]   bin_b_r;
   logic [W:0]     sum_r;

   function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
      logic [W-1:0] b;
      b[W-1] = g[W-1];
      for (int k = W - 2; k >= 0; k--) begin
         b[k] = b[k+1] ^ g[k];
      end
      return b;
   endfunction

   function automatic logic [W:0] bin2gray(input logic [W:0] s);
      return s ^ (s >> 1);
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_s = IDLE;
      case (state_r)
         IDLE:    next_s = take_s ? CONV : IDLE;
         CONV:    next_s = ADD;
         ADD:     next_s = ENC;
         ENC:     next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // Arbitration and FSM-derived outputs; on a tie the requester not served last wins
   always_comb begin
      take_s   = 1'b0;
      sel_id_s = 1'b0;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      busy     = (state_r != IDLE);
      if (req0 && req1) begin
         sel_id_s = ~last_id_r;
      end else if (req1) begin
         sel_id_s = 1'b1;
      end else begin
         sel_id_s = 1'b0;
      end
      if ((state_r == IDLE) && (req0 || req1)) begin
         take_s = 1'b1;
         gnt0   = ~sel_id_s;
         gnt1   = sel_id_s;
      end else begin
         take_s = 1'b0;
      end
   end

   // Operand capture, datapath stages and result registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         op_a_r    <= '0;
         op_b_r    <= '0;
         bin_a_r   <= '0;
         bin_b_r   <= '0;
         sum_r     <= '0;
         cur_id_r  <= 1'b0;
         last_id_r <= 1'b1;
         out_valid <= 1'b0;
         out_gray  <= '0;
         out_id    <= 1'b0;
         ops_cnt   <= 8'd0;
      end else begin
         out_valid <= (state_r == ENC);
         if (take_s) begin
            op_a_r    <= sel_id_s ? a1 : a0;
            op_b_r    <= sel_id_s ? b1 : b0;
            cur_id_r  <= sel_id_s;
            last_id_r <= sel_id_s;
         end
         case (state_r)
            CONV: begin
               bin_a_r <= gray2bin(op_a_r);
               bin_b_r <= gray2bin(op_b_r);
            end
            ADD: begin
               sum_r <= {1'b0, bin_a_r} + {1'b0, bin_b_r};
            end
            ENC: begin
               out_gray <= bin2gray(sum_r);
               out_id   <= cur_id_r;
               ops_cnt  <= ops_cnt + 8'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gray_add_sequencer.sv
// Directed bench for gray_add_sequencer: single ops, tie alternation with
// counter wrap, reset mid-sequence, and request changes while busy.
module tb_gray_add_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       req0, req1;
   logic [3:0] a0, b0, a1, b1;
   logic       gnt0, gnt1, busy, out_valid, out_id;
   logic [4:0] out_gray;
   logic [7:0] ops_cnt;

   int vectors = 0;
   int errs    = 0;

   always #5 clk = ~clk;

   gray_add_sequencer #(.W(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
      .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
      .busy(busy), .out_valid(out_valid), .out_gray(out_gray),
      .out_id(out_id), .ops_cnt(ops_cnt)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request from an idle block and check the whole sequence.
   task automatic single_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                            input logic [4:0] exp_gray, input logic [7:0] exp_cnt);
      if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
      else    begin req0 = 1'b1; a0 = a; b0 = b; end
      #1;
      chk("gnt0_at_grant", gnt0, !id);
      chk("gnt1_at_grant", gnt1, id);
      chk("busy_at_grant", busy, 1'b0);
      tick();
      req0 = 1'b0; req1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("busy_seq", busy, 1'b1);
         chk("valid_early", out_valid, 1'b0);
         chk("gnt_busy", {gnt0, gnt1}, 2'b00);
         tick();
      end
      chk("valid_pulse", out_valid, 1'b1);
      chk("out_gray", out_gray, exp_gray);
      chk("out_id", out_id, id);
      chk("ops_cnt", ops_cnt, exp_cnt);
      chk("busy_after", busy, 1'b0);
      tick();
      chk("valid_drop", out_valid, 1'b0);
      chk("gray_hold", out_gray, exp_gray);
   endtask

   initial begin
      logic       exp_id;
      logic [7:0] exp_cnt;
      reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
      a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
      tick(); tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_gray", out_gray, 5'd0);
      chk("rst_id", out_id, 1'b0);
      chk("rst_cnt", ops_cnt, 8'd0);
      chk("rst_gnt", {gnt0, gnt1}, 2'b00);
      reset_n = 1'b1;
      tick();
      chk("idle_gnt", {gnt0, gnt1}, 2'b00);

      single_op(1'b0, 4'b0000, 4'b0001, 5'b00001, 8'd1);
      single_op(1'b1, 4'b0011, 4'b0010, 5'b00111, 8'd2);
      single_op(1'b0, 4'b1111, 4'b1111, 5'b11110, 8'd3);

      // Both requesting from reset: alternating grants, counter wrap.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      req0 = 1'b1; a0 = 4'b0001; b0 = 4'b0001;
      req1 = 1'b1; a1 = 4'b0011; b1 = 4'b0011;
      #1;
      exp_id  = 1'b0;
      exp_cnt = 8'd0;
      for (int n = 0; n < 256; n++) begin
         chk("alt_gnt", {gnt0, gnt1}, exp_id ? 2'b01 : 2'b10);
         tick();
         chk("alt_gnt_busy", {gnt0, gnt1}, 2'b00);
         tick(); tick(); tick();
         exp_cnt = exp_cnt + 8'd1;
         chk("alt_valid", out_valid, 1'b1);
         chk("alt_id", out_id, exp_id);
         chk("alt_gray", out_gray, exp_id ? 5'b00110 : 5'b00011);
         chk("alt_cnt", ops_cnt, exp_cnt);
         exp_id = ~exp_id;
      end
      chk("wrap_cnt", ops_cnt, 8'd0);

      // Requester 0 wins next; reset hits during ADD.
      chk("pre_rst_gnt0", gnt0, 1'b1);
      tick();
      tick();
      chk("in_add_busy", busy, 1'b1);
      reset_n = 1'b0;
      tick();
      req0 = 1'b0; req1 = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_gray", out_gray, 5'd0);
      chk("mid_rst_cnt", ops_cnt, 8'd0);
      chk("mid_rst_id", out_id, 1'b0);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("no_late_valid", out_valid, 1'b0);
      end

      // Tie after reset goes to requester 0; req changes while busy ignored.
      req0 = 1'b1; a0 = 4'b0000; b0 = 4'b0001;
      req1 = 1'b1; a1 = 4'b1111; b1 = 4'b1111;
      #1;
      chk("tie_gnt", {gnt0, gnt1}, 2'b10);
      tick();
      req0 = 1'b0; req1 = 1'b1;
      #1;
      chk("tog_conv_gnt", {gnt0, gnt1}, 2'b00);
      tick();
      req0 = 1'b1; req1 = 1'b0; a0 = 4'b1111; b0 = 4'b1111;
      #1;
      chk("tog_add_gnt", {gnt0, gnt1}, 2'b00);
      tick();
      req0 = 1'b0; req1 = 1'b1; a1 = 4'b0001; b1 = 4'b0001;
      #1;
      chk("tog_enc_gnt", {gnt0, gnt1}, 2'b00);
      tick();
      chk("tog_valid", out_valid, 1'b1);
      chk("tog_gray", out_gray, 5'b00001);
      chk("tog_id", out_id, 1'b0);
      chk("tog_cnt", ops_cnt, 8'd1);
      chk("idle_gnt1", {gnt0, gnt1}, 2'b01);
      tick();
      req1 = 1'b0;
      tick(); tick(); tick();
      chk("last_valid", out_valid, 1'b1);
      chk("last_gray", out_gray, 5'b00011);
      chk("last_id", out_id, 1'b1);
      chk("last_cnt", ops_cnt, 8'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/gray_add_sequencer.md
# gray_add_sequencer

Sequencing controller that shares a single gray-code adder datapath between two requesters. Each requester presents two W-bit gray-code operands; the block arbitrates round-robin, captures the winner's operands, and steps a multi-cycle gray→binary, add, binary→gray sequence. It returns a (W+1)-bit gray-code sum tagged with the requester ID. It sits between the operand sources and the consumer of the gray sum, replacing per-requester adder copies.

## Interface
- W, default 4, operand width in bits; sum width is W+1.
- clk  input  1  clock; all state changes on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req0  input  1  requester 0 has a valid operand pair.
- a0, b0  input  W each  requester 0 gray-code operands.
- gnt0  output  1  requester 0 operands captured at this edge.
- req1, a1, b1, gnt1  same as requester 0, for requester 1.
- busy  output  1  sequence in progress; high in any state other than IDLE.
- out_valid  output  1  one-cycle pulse; out_gray and out_id are new.
- out_gray  output  W+1  gray-code sum of the last completed operation.
- out_id  output  1  requester that owns out_gray.
- ops_cnt  output  8  completed-operation count; wraps from 255 to 0.

## Operation
- FSM states: IDLE → CONV → ADD → ENC → IDLE. No other transitions.
- IDLE, arbitration:
  - gnt_i is combinational: (state==IDLE) and requester i is selected.
  - Only req0: grant 0. Only req1: grant 1.
  - Both requesting: grant the requester that is not last_id.
  - No request: no grant; stay in IDLE.
  - On a granting edge: capture a_i and b_i into opA/opB, set cur_id=i and last_id=i, go to CONV.
- CONV: convert opA and opB gray→binary and register both. Conversion rule: bin[W-1]=g[W-1]; bin[k]=bin[k+1]^g[k].
- ADD: register sum = binA + binB, zero-extended to W+1 bits, so no overflow is possible.
- ENC:
  - Register out_gray = sum ^ (sum>>1).
  - Set out_id=cur_id.
  - Pulse out_valid for one cycle.
  - Increment ops_cnt.
  - Return to IDLE.
- Requester protocol:
  - Hold req_i, a_i and b_i stable until gnt_i is sampled high.
  - Drop req_i in the cycle after the grant unless issuing a new request.
  - req changes while busy are ignored; nothing is queued internally.
- out_gray and out_id hold their value until the next ENC.
- Reset (reset_n low at an edge), from any state including mid-sequence:
  - state=IDLE, last_id=1, so requester 0 wins the first tie.
  - out_valid=0, out_gray=0, out_id=0, ops_cnt=0, internal operand and sum registers=0.
  - An in-flight operation is discarded: no out_valid is produced for it.
- Reset dominates every other event at the same edge.

## Timing
- Grant at edge T (gnt_i high in the cycle before edge T).
- CONV occupies the cycle after T, ADD the next, ENC the next.
- out_valid is high for exactly the one cycle after the ENC edge, i.e. 3 cycles after T.
- The FSM is back in IDLE in the same cycle out_valid is high, so a new grant may occur in that cycle.
- Peak throughput: one operation per 4 cycles.
- Outputs after reset release: gnt0=gnt1=0 unless a req is present in IDLE; busy=0.

## Test plan
- Reset, then req0 with a0=0000, b0=0001: gnt0 for one cycle, busy for 3 cycles, then out_valid with out_gray=00001, out_id=0, ops_cnt=1.
- req1 with a1=0011, b1=0010 (binary 2+3=5): out_gray=00111, out_id=1, 3 cycles after the grant.
- Max operands a=b=1111 (binary 10+10=20): out_gray=11110.
- req0 and req1 held high continuously from reset:
  - Grants alternate 0,1,0,1 with grants 4 cycles apart.
  - out_id alternates the same way.
  - ops_cnt increments once per out_valid and wraps 255→0 on the 256th completion.
- reset_n asserted during ADD: no out_valid, out_gray=0, ops_cnt=0, busy=0 next cycle. After release, a simultaneous req0/req1 grants requester 0 first.
- req toggled while busy: no gnt and no captured operands until IDLE; the value held on req at IDLE decides the next grant.
